// File: rtl/mux_n1_pipe.sv
// mux_n1_pipe: N-to-1 registered mux, fixed-select or round-robin grant, valid/ready per channel.
// Define MUX_N1_PARITY_EN to add a registered even-parity output (out_parity).
module mux_n1_pipe #(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
`ifdef MUX_N1_PARITY_EN
  output logic               out_parity,
`endif
  input  logic               out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_src;
  logic             r_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_accept;
  logic             w_fx_vld;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_grant;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  // Out-of-range sel matches no channel, so it never grants.
  always_comb begin
    w_fx_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) w_fx_vld = in_valid[i];
    end
  end

  // Search order starts one past the last winner; k-th candidate is (ptr+k) mod N.
  always_comb begin
    w_rr_vld   = 1'b0;
    w_rr_grant = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_rr_vld && in_valid[i] &&
            ((int'(r_rr_ptr) + k == i) || (int'(r_rr_ptr) + k == i + N))) begin
          w_rr_vld   = 1'b1;
          w_rr_grant = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    w_accept  = !r_valid || out_ready;
    w_gnt_vld = mode ? w_rr_vld : w_fx_vld;
    w_grant   = mode ? w_rr_grant : sel;
    w_xfer    = w_accept && w_gnt_vld;
  end

  always_comb begin
    w_sel_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_xfer;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_src    <= '0;
      r_valid  <= 1'b0;
      r_rr_ptr <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_data  <= w_sel_data;
      r_src   <= w_grant;
      r_valid <= 1'b1;
      if (mode) r_rr_ptr <= w_grant;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_N1_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_xfer) begin
      r_parity <= ^w_sel_data;
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_n1_pipe.sv
// tb_mux_n1_pipe: scoreboard bench for mux_n1_pipe (N=4 main instance, N=3 instance for sel>=N).
// Parity checks are included when MUX_N1_PARITY_EN is defined.
module tb_mux_n1_pipe;
  localparam int W  = 64;
  localparam int NA = 4;
  localparam int SA = 2;
  localparam int NB = 3;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [NA*W-1:0] a_data;
  logic [NA-1:0]   a_valid;
  logic [NA-1:0]   a_in_ready;
  logic            a_mode;
  logic [SA-1:0]   a_sel;
  logic [W-1:0]    a_out_data;
  logic [SA-1:0]   a_out_src;
  logic            a_out_valid;
  logic            a_ordy;

  logic [NB*W-1:0] b_data;
  logic [NB-1:0]   b_valid;
  logic [NB-1:0]   b_in_ready;
  logic            b_mode;
  logic [SB-1:0]   b_sel;
  logic [W-1:0]    b_out_data;
  logic [SB-1:0]   b_out_src;
  logic            b_out_valid;
  logic            b_ordy;
`ifdef MUX_N1_PARITY_EN
  logic            a_par;
  logic            b_par;
`endif

  mux_n1_pipe #(.WIDTH(W), .N(NA)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel), .out_data(a_out_data), .out_src(a_out_src),
    .out_valid(a_out_valid),
`ifdef MUX_N1_PARITY_EN
    .out_parity(a_par),
`endif
    .out_ready(a_ordy));

  mux_n1_pipe #(.WIDTH(W), .N(NB)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel), .out_data(b_out_data), .out_src(b_out_src),
    .out_valid(b_out_valid),
`ifdef MUX_N1_PARITY_EN
    .out_parity(b_par),
`endif
    .out_ready(b_ordy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SA-1:0] s;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  int          log_src[$];
  bit          stage_full = 1'b0;
  int          rr = NA - 1;
  bit          mon_en = 1'b0;
  logic [W-1:0] chd [NA];
  bit          force_en = 1'b0;
  int          force_ch = 0;
  logic [W-1:0] force_val = '0;
  logic [NA-1:0] last_ready;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor: compares the presented word with the scoreboard head, pops on consumption.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      chk("out_valid", 64'(a_out_valid), 64'(stage_full));
      if (a_out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: actual=out_valid=1 expected=no word pending");
        end else begin
          chk("out_data", a_out_data, sb_q[0].d);
          chk("out_src", 64'(a_out_src), 64'(sb_q[0].s));
`ifdef MUX_N1_PARITY_EN
          chk("out_parity", 64'(a_par), 64'(^sb_q[0].d));
`endif
          if (a_ordy) begin
            log_src.push_back(int'(a_out_src));
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  // One cycle of stimulus on dut_a; entered and left at posedge+1.
  task automatic drive(input logic [NA-1:0] v, input logic m, input logic [SA-1:0] s,
                       input logic ordy);
    logic acc;
    logic gv;
    int   g;
    int   idx;
    logic [NA-1:0] er;
    exp_t e;
    for (int i = 0; i < NA; i++) begin
      chd[i] = {$urandom, $urandom};
      if (force_en && force_ch == i) chd[i] = force_val;
      a_data[i*W +: W] = chd[i];
    end
    a_valid = v;
    a_mode  = m;
    a_sel   = s;
    a_ordy  = ordy;
    #1;
    acc = !stage_full || ordy;
    gv  = 1'b0;
    g   = 0;
    if (!m) begin
      if (int'(s) < NA && v[s]) begin
        gv = 1'b1;
        g  = int'(s);
      end
    end else begin
      for (int k = 1; k <= NA && !gv; k++) begin
        idx = (rr + k) % NA;
        if (v[idx]) begin
          gv = 1'b1;
          g  = idx;
        end
      end
    end
    er = '0;
    if (acc && gv) er[g] = 1'b1;
    last_ready = a_in_ready;
    chk("in_ready", 64'(a_in_ready), 64'(er));
    @(posedge clk);
    if (acc && gv) begin
      e.d = chd[g];
      e.s = SA'(g);
      sb_q.push_back(e);
      stage_full = 1'b1;
      if (m) rr = g;
    end else if (acc) begin
      stage_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input bit expect_full);
    mon_en  = 1'b0;
    a_valid = '0;
    b_valid = '0;
    if (expect_full) chk("pre_rst_valid", 64'(a_out_valid), 64'(1));
    #1 reset = 1'b0;
    #1;
    chk("rst_a_valid", 64'(a_out_valid), 64'(0));
    chk("rst_a_data", a_out_data, 64'(0));
    chk("rst_a_src", 64'(a_out_src), 64'(0));
    chk("rst_b_valid", 64'(b_out_valid), 64'(0));
    chk("rst_b_data", b_out_data, 64'(0));
`ifdef MUX_N1_PARITY_EN
    chk("rst_a_par", 64'(a_par), 64'(0));
`endif
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(a_out_valid), 64'(0));
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    stage_full = 1'b0;
    rr = NA - 1;
    sb_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp4 [6];
    int exp5 [4];
    exp4 = '{0, 1, 2, 3, 0, 1};
    exp5 = '{1, 3, 1, 3};
    a_data = '0; a_valid = '0; a_mode = 1'b0; a_sel = '0; a_ordy = 1'b0;
    b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = '0; b_ordy = 1'b0;
    do_reset(1'b0);

    // N=3 instance: valid select, then out-of-range select
    b_mode = 1'b0; b_sel = 2'd0; b_valid = 3'b111; b_ordy = 1'b1;
    b_data = {64'($urandom), 64'($urandom), 64'd64357};
    #1;
    chk("b_in_ready_sel0", 64'(b_in_ready), 64'(3'b001));
    @(posedge clk); #1;
    chk("b_valid_sel0", 64'(b_out_valid), 64'(1));
    chk("b_data_sel0", b_out_data, 64'd64357);
    chk("b_src_sel0", 64'(b_out_src), 64'(0));
`ifdef MUX_N1_PARITY_EN
    chk("b_parity", 64'(b_par), 64'(1));
`endif
    b_sel = 2'd3;
    #1;
    chk("b_in_ready_sel3", 64'(b_in_ready), 64'(0));
    @(posedge clk); #1;
    chk("b_valid_sel3", 64'(b_out_valid), 64'(0));
    chk("b_data_hold", b_out_data, 64'd64357);
    b_valid = '0;

    // fixed select sel=2
    force_en = 1'b1; force_ch = 2; force_val = 64'd26000;
    drive(4'b1111, 1'b0, 2'd2, 1'b1);
    chk("t2_in_ready", 64'(last_ready), 64'(4'b0100));
    chk("t2_valid", 64'(a_out_valid), 64'(1));
    chk("t2_data", a_out_data, 64'd26000);
    chk("t2_src", 64'(a_out_src), 64'(2));

    // stall with ch0 waiting, then release
    force_ch = 0; force_val = 64'd64357;
    repeat (3) begin
      drive(4'b0001, 1'b0, 2'd0, 1'b0);
      chk("t3_stall_ready", 64'(last_ready), 64'(0));
      chk("t3_stall_data", a_out_data, 64'd26000);
    end
    drive(4'b0001, 1'b0, 2'd0, 1'b1);
    chk("t3_release_ready", 64'(last_ready), 64'(4'b0001));
    chk("t3_new_data", a_out_data, 64'd64357);
    chk("t3_new_src", 64'(a_out_src), 64'(0));
    force_en = 1'b0;

    // async reset with a word held in the stage
    do_reset(1'b1);

    // round robin, all channels requesting
    log_src.delete();
    repeat (7) drive(4'b1111, 1'b1, 2'd0, 1'b1);
    chk("t4_count", 64'(log_src.size() >= 6), 64'(1));
    for (int i = 0; i < 6 && i < log_src.size(); i++) chk("t4_src_seq", 64'(log_src[i]), 64'(exp4[i]));

    // round robin over channels 1 and 3, then no requests
    do_reset(1'b0);
    log_src.delete();
    repeat (5) drive(4'b1010, 1'b1, 2'd0, 1'b1);
    drive(4'b0000, 1'b1, 2'd0, 1'b1);
    chk("t5_drop_valid", 64'(a_out_valid), 64'(0));
    chk("t5_count", 64'(log_src.size() >= 4), 64'(1));
    for (int i = 0; i < 4 && i < log_src.size(); i++) chk("t5_src_seq", 64'(log_src[i]), 64'(exp5[i]));

    // randomized traffic against the model
    repeat (400) begin
      drive(NA'($urandom), 1'($urandom_range(0, 1)), SA'($urandom),
            1'($urandom_range(0, 3) != 0));
    end
    drive('0, 1'b0, 2'd0, 1'b1);
    drive('0, 1'b0, 2'd0, 1'b1);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
